register_2bits: RTL and testbench
=================================

# register_2bits

Two-bit storage register with synchronous load-enable, asynchronous active-high clear and complementary outputs. It is the basic state-holding element of the alarm-clock datapath; wider registers and counters are built by instancing it. It is built structurally: per bit, an enable multiplexer feeds an edge-triggered D flip-flop with asynchronous clear, and each bit drives both a true and an inverted output.

## Interface

- Parameters: none. Width is fixed at 2 bits.
- Positional port order is Q, Q_n, D, clear, clock, enable.
- `clock`  input  1  Single clock for the block. State updates on the rising edge only.
- `clear`  input  1  Reset, asynchronous and active-high. While it is 1, Q = 2'b00 and Q_n = 2'b11.
- `Q`  output  2  Stored value. Q[1] is the MSB.
- `Q_n`  output  2  Bitwise complement of Q at all times.
- `D`  input  2  Data to load.
- `enable`  input  1  Load enable, active-high. When it is 0 the register holds its value.

## Operation

- Each bit i is built from three parts:
  - a 2:1 mux that selects D[i] when enable = 1 and Q[i] when enable = 0;
  - a positive-edge D flip-flop with asynchronous clear;
  - an inverter or complementary flip-flop output that produces Q_n[i].
- Priority, from highest to lowest:
  - clear = 1 forces Q = 00 and Q_n = 11, regardless of clock, enable or D.
  - Otherwise, at a rising clock edge with enable = 1, Q takes D.
  - Otherwise, Q holds its value.
- Both bits always load together. There is no per-bit enable.
- The invariant Q_n == ~Q holds in every state, including reset.
- The register is undefined until the first clear or the first enabled load. Users must assert clear at power-up.
- enable and D are sampled only at the rising edge. Changes between edges have no effect.
- Falling clock edges never change state.

## Timing

- Reset value: Q = 2'b00, Q_n = 2'b11.
  - Clear assertion takes effect asynchronously, with no clock needed. Outputs change within the same simulation time step, after gate delay only.
- Clear deassertion: the first possible load is the next rising edge at which clear = 0 and enable = 1.
- Clear and a rising edge at the same time: clear wins. Q = 00 and the load is discarded.
- Clear asserted mid-hold or just after a load: Q goes to 00 at once. The earlier value is lost.
- Load latency: one edge. D sampled at rising edge k appears on Q, and its complement on Q_n, right after edge k.
- No combinational path from D or enable to Q or Q_n.
- enable = 0 across any number of edges: Q stays constant.
- Setup and hold on D and enable relative to the rising clock edge follow the library flip-flop.

## Test plan

- **Async clear:** D = 01, enable = 0, clock = 0, then clear = 1 -> Q = 00 and Q_n = 11 at once, before any clock edge.
- **Enabled load:** clear = 0, enable = 1, D = 01, one rising edge -> Q = 01, Q_n = 10. Then D = 11 and another rising edge -> Q = 11, Q_n = 00.
- **Hold:** Q = 01, enable = 0, D = 10, three rising edges -> Q stays 01 and Q_n stays 10. Then enable = 1 and one edge -> Q = 10.
- **Edge sensitivity:** enable = 1, D changed from 01 to 11 while clock is high, then a falling edge -> Q unchanged. The next rising edge -> Q = 11.
- **Clear priority:** Q = 11, enable = 1, D = 10, clear = 1 held across a rising edge -> Q = 00 and Q_n = 11 throughout. Release clear, one enabled edge -> Q = 10.
- **Complement check:** at every sample point in all scenarios above, Q_n == ~Q, including reset and holds.

Source files
------------

// File: rtl/register_2bits.sv
// Two-bit load-enabled register with asynchronous active-high clear and
// complementary outputs; the basic state element of the alarm-clock datapath.
module register_2bits (
  output logic [1:0] Q,
  output logic [1:0] Q_n,
  input  logic [1:0] D,
  input  logic       clear,
  input  logic       clock,
  input  logic       enable
);

  logic [1:0] next_q;

  // Each bit is an enable mux recirculating Q, feeding a clearable D flip-flop.
  for (genvar i = 0; i < 2; i++) begin : g_bit
    logic q_bit;

    assign next_q[i] = enable ? D[i] : Q[i];

    always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
        q_bit <= 1'b0;
      end else begin
        q_bit <= next_q[i];
      end
    end

    assign Q[i]   = q_bit;
    assign Q_n[i] = ~q_bit;
  end

endmodule

// File: tb/tb_register_2bits.sv
// Self-checking bench for register_2bits: table-driven vectors plus hand-written
// sequences for async clear, edge sensitivity and clear priority.
module tb_register_2bits;

  logic [1:0] Q;
  logic [1:0] Q_n;
  logic [1:0] D;
  logic       clear;
  logic       clock;
  logic       enable;

  int pass_count  = 0;
  int check_count = 0;

  logic [1:0] exp_queue[$];

  typedef struct {
    string      name;
    logic       clear;
    logic       enable;
    logic [1:0] d;
    logic [1:0] exp_q;
  } vec_t;

  vec_t vecs[11];

  register_2bits dut (
    .Q      (Q),
    .Q_n    (Q_n),
    .D      (D),
    .clear  (clear),
    .clock  (clock),
    .enable (enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expect_q(input logic [1:0] exp_val);
    exp_queue.push_back(exp_val);
  endtask

  task automatic check_output(input string name);
    logic [1:0] exp_val;
    logic [1:0] exp_n;
    check_count++;
    if (exp_queue.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, actual Q=%b", name, Q);
      return;
    end
    exp_val = exp_queue.pop_front();
    exp_n   = ~exp_val;
    if (Q === exp_val) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: Q=%b expected %b", name, Q, exp_val);
    end
    check_count++;
    if (Q_n === exp_n) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s_n: Q_n=%b expected %b", name, Q_n, exp_n);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic apply_stimulus(input logic c, input logic en, input logic [1:0] d,
                                input logic [1:0] exp_val, input string name);
    @(negedge clock);
    clear  = c;
    enable = en;
    D      = d;
    expect_q(exp_val);
    @(posedge clock);
    #1;
    check_output(name);
  endtask

  initial begin
    vecs[0]  = '{"load_01",      1'b0, 1'b1, 2'b01, 2'b01};
    vecs[1]  = '{"load_11",      1'b0, 1'b1, 2'b11, 2'b11};
    vecs[2]  = '{"load_01b",     1'b0, 1'b1, 2'b01, 2'b01};
    vecs[3]  = '{"hold_1",       1'b0, 1'b0, 2'b10, 2'b01};
    vecs[4]  = '{"hold_2",       1'b0, 1'b0, 2'b10, 2'b01};
    vecs[5]  = '{"hold_3",       1'b0, 1'b0, 2'b10, 2'b01};
    vecs[6]  = '{"load_10",      1'b0, 1'b1, 2'b10, 2'b10};
    vecs[7]  = '{"hold_10",      1'b0, 1'b0, 2'b00, 2'b10};
    vecs[8]  = '{"clear_edge",   1'b1, 1'b1, 2'b01, 2'b00};
    vecs[9]  = '{"post_clear",   1'b0, 1'b1, 2'b10, 2'b10};
    vecs[10] = '{"load_00",      1'b0, 1'b1, 2'b00, 2'b00};

    clear  = 1'b0;
    enable = 1'b0;
    D      = 2'b01;

    // Async clear before any clock edge.
    #2;
    clear = 1'b1;
    expect_q(2'b00);
    #1;
    check_output("async_clear");
    @(posedge clock);
    #1;
    expect_q(2'b00);
    check_output("clear_held");

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].clear, vecs[i].enable, vecs[i].d, vecs[i].exp_q, vecs[i].name);
    end

    // Edge sensitivity: D changes while clock is high, falling edge must not load.
    apply_stimulus(1'b0, 1'b1, 2'b01, 2'b01, "edge_load_01");
    D = 2'b11;
    expect_q(2'b01);
    @(negedge clock);
    #1;
    check_output("edge_fall_hold");
    expect_q(2'b11);
    @(posedge clock);
    #1;
    check_output("edge_rise_11");

    // Clear priority: clear asserted with enable high, held across a rising edge.
    @(negedge clock);
    D     = 2'b10;
    clear = 1'b1;
    expect_q(2'b00);
    #1;
    check_output("prio_clear_now");
    expect_q(2'b00);
    @(posedge clock);
    #1;
    check_output("prio_clear_edge");
    apply_stimulus(1'b0, 1'b1, 2'b10, 2'b10, "prio_release");

    // Clear just after a load wipes the new value at once.
    apply_stimulus(1'b0, 1'b1, 2'b11, 2'b11, "late_load_11");
    enable = 1'b0;
    #2;
    clear = 1'b1;
    expect_q(2'b00);
    #1;
    check_output("late_clear");
    @(negedge clock);
    clear = 1'b0;
    apply_stimulus(1'b0, 1'b0, 2'b01, 2'b00, "hold_after_clear");

    if (exp_queue.size() != 0) begin
      check_count++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_queue.size());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
